// File: rtl/cursor_nav_ctrl.sv
// Debounced 4x4 grid cursor controller with press/auto-repeat events.
// Cursor moves land in next_pos at once and are shown at frame start.
module cursor_nav_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       enable,
  input  logic       frame_start,
  output logic [3:0] pos_cursor,
  output logic       move_pending,
  output logic       sel_pulse,
  output logic [3:0] sel_index
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  localparam int SEL = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  logic [4:0]    raw;
  logic [4:0]    sync1_q;
  logic [4:0]    sync2_q;
  logic [4:0]    stable_q;
  logic [4:0]    prev_q;
  logic [4:0]    press_q;
  logic [DW-1:0] db_cnt_q [5];

  logic [3:0]    next_pos_q;
  logic [3:0]    pos_q;
  logic          pend_q;
  logic          sel_pulse_q;
  logic [3:0]    sel_idx_q;

  state_e        state_q;
  logic [RW-1:0] rep_cnt_q;
  logic [1:0]    rep_dir_q;

  logic [3:0]    prs;
  logic          press_any;
  logic [1:0]    pdir;
  logic          rep_ev;
  logic          apply;
  logic [1:0]    mdir;
  logic [1:0]    row;
  logic [1:0]    col;
  logic [3:0]    moved;
  logic          sel_ev;

  // Bit order: up, down, left, right, select.
  assign raw = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      press_q  <= '0;
      for (int i = 0; i < 5; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= stable_q;
      press_q <= stable_q & ~prev_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          stable_q[i] <= ~stable_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign prs       = press_q[3:0] & {4{enable}};
  assign press_any = |prs;
  assign sel_ev    = press_q[SEL] & enable;

  assign rep_ev = enable && stable_q[rep_dir_q] &&
                  (((state_q == HOLD)   && (rep_cnt_q == HOLD_LAST)) ||
                   ((state_q == REPEAT) && (rep_cnt_q == REP_LAST)));

  // Priority encoder: up > down > left > right.
  always_comb begin
    pdir = 2'd3;
    if (prs[0])      pdir = 2'd0;
    else if (prs[1]) pdir = 2'd1;
    else if (prs[2]) pdir = 2'd2;
  end

  assign apply = press_any | rep_ev;
  assign mdir  = press_any ? pdir : rep_dir_q;
  assign row   = next_pos_q[3:2];
  assign col   = next_pos_q[1:0];

  always_comb begin
    moved = next_pos_q;
    unique case (mdir)
      2'd0: moved = {row - 2'd1, col};
      2'd1: moved = {row + 2'd1, col};
      2'd2: moved = {row, col - 2'd1};
      2'd3: moved = {row, col + 2'd1};
      default: moved = next_pos_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_pos_q  <= '0;
      pos_q       <= '0;
      pend_q      <= 1'b0;
      sel_pulse_q <= 1'b0;
      sel_idx_q   <= '0;
    end else begin
      if (apply) next_pos_q <= moved;
      if (frame_start) pos_q <= next_pos_q;
      pend_q      <= (next_pos_q != pos_q);
      sel_pulse_q <= sel_ev;
      if (sel_ev) sel_idx_q <= next_pos_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
      rep_dir_q <= '0;
    end else if (press_any) begin
      state_q   <= HOLD;
      rep_dir_q <= pdir;
      rep_cnt_q <= '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (!stable_q[rep_dir_q]) begin
            state_q <= IDLE;
          end else if (rep_cnt_q == HOLD_LAST) begin
            state_q   <= REPEAT;
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (!stable_q[rep_dir_q]) begin
            state_q <= IDLE;
          end else if (rep_cnt_q == REP_LAST) begin
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          rep_cnt_q <= '0;
        end
      endcase
    end
  end

  assign pos_cursor   = pos_q;
  assign move_pending = pend_q;
  assign sel_pulse    = sel_pulse_q;
  assign sel_index    = sel_idx_q;

endmodule

// File: tb/tb_cursor_nav_ctrl.sv
// Bench for cursor_nav_ctrl: queued expected cursor moves and selects
// are compared, with their arrival cycle, as the design produces them.
module tb_cursor_nav_ctrl;

  localparam int DB = 4;
  localparam int HC = 20;
  localparam int RC = 8;

  localparam int UP = 0;
  localparam int DN = 1;
  localparam int LT = 2;
  localparam int RT = 3;
  localparam int SL = 4;

  typedef struct {
    logic [3:0] val;
    int         cyc;
  } np_exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn = '0;
  logic       enable = 1'b1;
  logic       frame_start = 1'b0;
  logic [3:0] pos_cursor;
  logic       move_pending;
  logic       sel_pulse;
  logic [3:0] sel_index;

  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  logic [3:0] last_np = '0;
  logic [3:0] mp = '0;
  np_exp_t    np_q [$];
  logic [3:0] sel_q [$];

  cursor_nav_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_up      (btn[UP]),
    .btn_down    (btn[DN]),
    .btn_left    (btn[LT]),
    .btn_right   (btn[RT]),
    .btn_sel     (btn[SL]),
    .enable      (enable),
    .frame_start (frame_start),
    .pos_cursor  (pos_cursor),
    .move_pending(move_pending),
    .sel_pulse   (sel_pulse),
    .sel_index   (sel_index)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] p, input int d);
    int r;
    int c;
    r = int'(p) / 4;
    c = int'(p) % 4;
    case (d)
      UP:      r = (r + 3) % 4;
      DN:      r = (r + 1) % 4;
      LT:      c = (c + 3) % 4;
      default: c = (c + 1) % 4;
    endcase
    return 4'(r * 4 + c);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input logic [4:0] m, input int dir, input bit mv);
    if (mv) begin
      mp = nxt(mp, dir);
      np_q.push_back('{mp, cyc + 8});
    end
    btn = m;
    step(10);
    btn = '0;
    step(12);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  // Monitor samples 1 time unit after each rising edge.
  always @(posedge clk) begin : mon
    np_exp_t e;
    cyc++;
    #1;
    if (reset) begin
      last_np = dut.next_pos_q;
    end else begin
      if (dut.next_pos_q !== last_np) begin
        if (np_q.size() == 0) begin
          check_eq("np_unexpected", 32'(dut.next_pos_q), 32'(last_np));
        end else begin
          e = np_q.pop_front();
          check_eq("np_value", 32'(dut.next_pos_q), 32'(e.val));
          check_eq("np_cycle", 32'(cyc), 32'(e.cyc));
        end
        last_np = dut.next_pos_q;
      end
      if (sel_pulse) begin
        if (sel_q.size() == 0)
          check_eq("sel_unexpected", 32'(sel_pulse), 32'd0);
        else
          check_eq("sel_index", 32'(sel_index), 32'(sel_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    int r;

    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check_eq("rst_pos", 32'(pos_cursor), 32'd0);
    check_eq("rst_pend", 32'(move_pending), 32'd0);
    check_eq("rst_sel_pulse", 32'(sel_pulse), 32'd0);
    check_eq("rst_sel_index", 32'(sel_index), 32'd0);
    check_eq("rst_next_pos", 32'(dut.next_pos_q), 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'd0);

    btn[RT] = 1'b1;
    step(2);
    btn = '0;
    step(12);
    check_eq("glitch_np", 32'(dut.next_pos_q), 32'd0);

    mp = '0;
    tap(5'b01000, RT, 1'b1);
    check_eq("pend_set", 32'(move_pending), 32'd1);
    check_eq("pos_before_frame", 32'(pos_cursor), 32'd0);
    pulse_frame();
    check_eq("pos_after_frame", 32'(pos_cursor), 32'd1);
    step(1);
    check_eq("pend_clear", 32'(move_pending), 32'd0);

    tap(5'b01000, RT, 1'b1);
    tap(5'b01000, RT, 1'b1);
    tap(5'b01000, RT, 1'b1);
    tap(5'b00001, UP, 1'b1);
    tap(5'b00010, DN, 1'b1);
    tap(5'b00010, DN, 1'b1);
    tap(5'b00100, LT, 1'b1);
    tap(5'b01000, RT, 1'b1);
    tap(5'b01000, RT, 1'b1);
    check_eq("at_five", 32'(dut.next_pos_q), 32'd5);

    tap(5'b01001, UP, 1'b1);
    check_eq("prio_up_right", 32'(dut.next_pos_q), 32'd1);
    tap(5'b00010, DN, 1'b1);
    sel_q.push_back(mp);
    tap(5'b10010, DN, 1'b1);
    check_eq("sel_hold", 32'(sel_index), 32'd5);
    check_eq("sel_move", 32'(dut.next_pos_q), 32'd9);
    pulse_frame();
    check_eq("pos_nine", 32'(pos_cursor), 32'd9);

    tap(5'b00100, LT, 1'b1);
    c = cyc;
    np_q.push_back('{4'd9,  c + 8});
    np_q.push_back('{4'd10, c + 8 + HC});
    np_q.push_back('{4'd11, c + 8 + HC + RC});
    np_q.push_back('{4'd8,  c + 8 + HC + 2 * RC});
    mp = 4'd8;
    btn[RT] = 1'b1;
    step(8 + HC + 2 * RC);
    btn = '0;
    step(20);
    check_eq("rep_idle", 32'(dut.state_q), 32'd0);
    check_eq("rep_final", 32'(dut.next_pos_q), 32'd8);

    enable = 1'b0;
    tap(5'b00001, UP, 1'b0);
    tap(5'b10000, SL, 1'b0);
    check_eq("dis_np", 32'(dut.next_pos_q), 32'd8);
    check_eq("dis_state", 32'(dut.state_q), 32'd0);
    check_eq("dis_sel_index", 32'(sel_index), 32'd5);
    check_eq("dis_pend", 32'(move_pending), 32'd1);
    pulse_frame();
    step(1);
    check_eq("dis_commit", 32'(pos_cursor), 32'd8);
    check_eq("dis_pend_clr", 32'(move_pending), 32'd0);
    enable = 1'b1;

    c = cyc;
    mp = nxt(mp, RT);
    np_q.push_back('{mp, c + 8});
    btn[RT] = 1'b1;
    step(12);
    check_eq("hold_state", 32'(dut.state_q), 32'd1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    r = cyc;
    check_eq("mid_rst_np", 32'(dut.next_pos_q), 32'd0);
    check_eq("mid_rst_pos", 32'(pos_cursor), 32'd0);
    check_eq("mid_rst_pend", 32'(move_pending), 32'd0);
    check_eq("mid_rst_sel", 32'(sel_index), 32'd0);
    check_eq("mid_rst_state", 32'(dut.state_q), 32'd0);
    mp = nxt(4'd0, RT);
    np_q.push_back('{mp, r + 8});
    step(12);
    btn = '0;
    step(14);

    check_eq("np_queue_empty", 32'(np_q.size()), 32'd0);
    check_eq("sel_queue_empty", 32'(sel_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
